// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared encodings and widths for the pipeline hazard unit.
//   FWD_*  : execute-stage operand select encodings
//   REG_W  : register-index width
//   CNT_W  : multi-cycle busy counter width
package hazard_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    // A producer stage feeds a consumer register only when it actually
    // writes, targets the same index, and that index is not $zero.
    function automatic logic reg_hit(input logic             we,
                                     input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] src);
        return we && (dst == src) && (src != '0);
    endfunction

endpackage

// File: rtl/hazard_unit_md_busy_counter.sv
// md_busy_counter -- occupancy counter for the multi-cycle mult/div unit.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears counter)
//   start      : multi-cycle op enters execute this cycle
//   busy       : unit occupied (counter != 0), registered timing
// A start seen while already busy is ignored; the stall logic upstream
// keeps that from happening.
module md_busy_counter
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MD_LATENCY - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (count != '0)
            count_next = count - 1'b1;
        else if (start)
            count_next = LOAD_VAL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else
            count <= count_next;
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit -- forwarding and stall control for a 5-stage MIPS-style pipe.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   RsD/RtD, RsE/RtE         : decode / execute source registers
//   WriteReg{E,M,W}          : destination register per stage
//   RegWrite{E,M,W}          : destination write enable per stage
//   MemtoReg{E,M}            : stage holds a load
//   BranchD                  : decode holds a branch comparing RsD/RtD
//   MdUseD                   : decode needs the mult/div unit
//   MdStartE                 : multi-cycle op enters execute
//   ForwardAE/BE             : execute operand select (hazard_pkg::fwd_e)
//   ForwardAD/BD             : decode comparator takes ALUOutM
//   StallF/StallD/FlushE     : hold fetch, hold decode, bubble execute
//   MdBusy                   : multi-cycle unit occupied
//   StallCount               : saturating count of StallD cycles
//                              (only with HAZARD_STALL_CNT_EN defined)
// Everything except the busy counter (and optional stall counter) is
// combinational.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] RsD,
    input  logic [REG_W-1:0] RtD,
    input  logic [REG_W-1:0] RsE,
    input  logic [REG_W-1:0] RtE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic [REG_W-1:0] WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             MdUseD,
    input  logic             MdStartE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
`ifdef HAZARD_STALL_CNT_EN
    output logic [31:0]      StallCount,
`endif
    output logic             MdBusy
);

    logic lw_stall;
    logic br_stall;
    logic md_stall;
    logic stall;

    md_busy_counter #(.MD_LATENCY(MD_LATENCY)) u_md_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .start (MdStartE),
        .busy  (MdBusy)
    );

    // Memory stage is checked first so the youngest result wins.
    always_comb begin
        ForwardAE = FWD_RF;
        if (reg_hit(RegWriteM, WriteRegM, RsE))
            ForwardAE = FWD_MEM;
        else if (reg_hit(RegWriteW, WriteRegW, RsE))
            ForwardAE = FWD_WB;

        ForwardBE = FWD_RF;
        if (reg_hit(RegWriteM, WriteRegM, RtE))
            ForwardBE = FWD_MEM;
        else if (reg_hit(RegWriteW, WriteRegW, RtE))
            ForwardBE = FWD_WB;
    end

    assign ForwardAD = reg_hit(RegWriteM, WriteRegM, RsD);
    assign ForwardBD = reg_hit(RegWriteM, WriteRegM, RtD);

    // A load in execute delivers its data too late for the next instruction.
    assign lw_stall = MemtoRegE && (RtE != '0) && ((RtE == RsD) || (RtE == RtD));

    // Branch resolves in decode: wait for an ALU result still in execute,
    // or for a load still in memory (ALUOutM is not its data yet).
    assign br_stall = BranchD &&
                      (reg_hit(RegWriteE, WriteRegE, RsD) ||
                       reg_hit(RegWriteE, WriteRegE, RtD) ||
                       reg_hit(MemtoRegM, WriteRegM, RsD) ||
                       reg_hit(MemtoRegM, WriteRegM, RtD));

    assign md_stall = MdUseD && MdBusy;

    assign stall  = lw_stall || br_stall || md_stall;
    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            StallCount <= '0;
        else if (StallD && (StallCount != 32'hFFFF_FFFF))
            StallCount <= StallCount + 32'd1;
    end
`endif

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 4, execute-stage cycles of a multi-cycle multiply/divide op (legal 2..15).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: RsD, RtD  in  5 each  decode-stage source registers.
REQ-005 SHALL have ports: RsE, RtE  in  5 each  execute-stage source registers.
REQ-006 SHALL have ports: WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register per stage.
REQ-007 SHALL have ports: RegWriteE, RegWriteM, RegWriteW  in  1 each  destination-write enable per stage.
REQ-008 SHALL have ports: MemtoRegE, MemtoRegM  in  1 each  stage holds a load.
REQ-009 SHALL have ports: BranchD  in  1  decode holds a branch comparing RsD/RtD.
REQ-010 SHALL have ports: MdUseD  in  1  decode holds mult/div/mfhi/mflo.
REQ-011 SHALL have ports: MdStartE  in  1  multi-cycle op enters execute this cycle.
REQ-012 SHALL have ports: ForwardAE, ForwardBE  out  2 each  execute operand select: 00 register file, 01 writeback result, 10 ALUOutM.
REQ-013 SHALL have ports: ForwardAD, ForwardBD  out  1 each  decode branch comparator takes ALUOutM.
REQ-014 SHALL have ports: StallF, StallD, FlushE  out  1 each  hold fetch, hold decode, bubble execute.
REQ-015 SHALL have ports: MdBusy  out  1  multi-cycle unit occupied.

Function
REQ-016 ForwardAE SHALL be 10 when RegWriteM and WriteRegM==RsE!=0; else 01 when RegWriteW and WriteRegW==RsE!=0; else 00; ForwardBE identical using RtE.
REQ-017 Memory stage SHALL win over writeback when both match; register 0 SHALL never be forwarded.
REQ-018 ForwardAD SHALL be 1 iff RegWriteM and WriteRegM==RsD!=0; ForwardBD likewise with RtD.
REQ-019 Load-use stall SHALL assert when MemtoRegE and RtE!=0 and (RtE==RsD or RtE==RtD).
REQ-020 Branch stall SHALL assert when BranchD and ((RegWriteE and WriteRegE in {RsD,RtD}, nonzero) or (MemtoRegM and WriteRegM in {RsD,RtD}, nonzero)).
REQ-021 Md stall SHALL assert when MdUseD and MdBusy.
REQ-022 StallF, StallD, FlushE SHALL all equal OR of the three stall terms, combinationally, same cycle.
REQ-023 Md counter (4 bit) SHALL load MD_LATENCY-1 on the edge where MdStartE and counter==0; SHALL decrement by 1 each edge while nonzero; SHALL never wrap below 0.
REQ-024 MdBusy SHALL equal (counter!=0), registered-output timing: high the cycle after MdStartE for exactly MD_LATENCY-1 cycles.
REQ-025 MdStartE while counter!=0 SHALL be ignored (counter unaffected) -- cannot occur under REQ-021; the bench SHALL flag it as a protocol error.
REQ-026 All forwarding/stall outputs SHALL be purely combinational from inputs and counter; no other state.

Reset
REQ-027 rst_n low SHALL clear the counter asynchronously, forcing MdBusy=0 immediately, including mid-operation.
REQ-028 During reset, combinational outputs SHALL follow inputs with MdBusy=0; first load permitted on the first edge after deassertion.

Configuration
REQ-029 Macro HAZARD_STALL_CNT_EN defined SHALL add output StallCount (out, 32) counting cycles with StallD high, saturating at 0xFFFFFFFF, cleared by rst_n.
REQ-030 Macro undefined SHALL omit the StallCount port and counter; all other behaviour unchanged.

Structure
REQ-031 Package hazard_pkg SHALL hold forward encodings FWD_RF=00, FWD_WB=01, FWD_MEM=10, register-index width 5, counter width 4.
REQ-032 Sub-module md_busy_counter SHALL own REQ-023..025 and REQ-027; all other logic SHALL live in hazard_unit.

Verification
REQ-033 RegWriteM=1, WriteRegM=8, RegWriteW=1, WriteRegW=8, RsE=8 -> ForwardAE=10; drop RegWriteM -> 01; set RsE=0 with WriteRegM=0 -> 00.
REQ-034 MemtoRegE=1, RtE=9, RsD=9 -> StallF=StallD=FlushE=1 that cycle; RtE=0 -> all 0.
REQ-035 BranchD=1, RsD=5, RegWriteE=1, WriteRegE=5 -> stall 1; next cycle WriteRegM=5, RegWriteM=1, MemtoRegM=0 -> stall 0, ForwardAD=1.
REQ-036 MD_LATENCY=4: MdStartE pulse at edge 0 -> MdBusy high after edges 0..2, low after edge 3; MdUseD=1 throughout -> stall exactly 3 cycles.
REQ-037 rst_n pulsed low while counter=2 -> MdBusy drops without clock edge; next MdStartE reloads to 3.
REQ-038 With HAZARD_STALL_CNT_EN: 5 stall cycles -> StallCount=5; forced 0xFFFFFFFE plus 3 stalls -> 0xFFFFFFFF.
